// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// Module   : mem_port_arbiter
// Purpose  : Time-shares one unified memory port between IF fetches and
//            MEM-stage loads/stores. Optional counters: ARB_STATS_EN.
// Revision : 1.0 - initial release
// ------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W = 8
`ifdef ARB_STATS_EN
  ,
  parameter int STAT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_inst,
  output logic              if_valid,
  input  logic              ls_read,
  input  logic              ls_write,
  input  logic [2:0]        ls_funct3,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic [31:0]       ls_rdata,
  output logic              ls_done,
  output logic              ls_fault,
  output logic              stall,
  output logic              mem_read,
  output logic              mem_write,
  output logic [2:0]        mem_read_part,
  output logic [1:0]        mem_write_part,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
`ifdef ARB_STATS_EN
  output logic [STAT_W-1:0] stat_fetch,
  output logic [STAT_W-1:0] stat_stall,
`endif
  input  logic [31:0]       mem_rdata
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;

  localparam logic [1:0] c_SZ_B = 2'd0;
  localparam logic [1:0] c_SZ_H = 2'd1;
  localparam logic [1:0] c_SZ_W = 2'd2;

  localparam logic [2:0] c_RP_W  = 3'd0;
  localparam logic [2:0] c_RP_H  = 3'd1;
  localparam logic [2:0] c_RP_HU = 3'd2;
  localparam logic [2:0] c_RP_B  = 3'd3;
  localparam logic [2:0] c_RP_BU = 3'd4;

  localparam logic [1:0] c_WP_W = 2'd0;
  localparam logic [1:0] c_WP_H = 2'd1;
  localparam logic [1:0] c_WP_B = 2'd2;

  logic [1:0]  r_state;
  logic [31:0] r_if_inst;
  logic        r_if_valid;
  logic [31:0] r_ls_rdata;
  logic        r_ls_done;
  logic        r_ls_fault;

  logic        w_is_fetch;
  logic        w_is_data;
  logic        w_ls_req;
  logic [2:0]  w_rd_part;
  logic        w_rd_legal;
  logic [1:0]  w_rd_size;
  logic [1:0]  w_wr_part;
  logic        w_wr_legal;
  logic [1:0]  w_wr_size;
  logic [1:0]  w_size;
  logic        w_legal;
  logic        w_aligned;
  logic        w_ok;

  assign w_is_fetch = (r_state == S_FETCH);
  assign w_is_data  = (r_state == S_DATA);
  assign w_ls_req   = ls_read | ls_write;

  always_comb begin
    w_rd_part  = c_RP_W;
    w_rd_legal = 1'b0;
    w_rd_size  = c_SZ_W;
    case (ls_funct3)
      3'b000: begin w_rd_part = c_RP_B;  w_rd_legal = 1'b1; w_rd_size = c_SZ_B; end
      3'b001: begin w_rd_part = c_RP_H;  w_rd_legal = 1'b1; w_rd_size = c_SZ_H; end
      3'b010: begin w_rd_part = c_RP_W;  w_rd_legal = 1'b1; w_rd_size = c_SZ_W; end
      3'b100: begin w_rd_part = c_RP_BU; w_rd_legal = 1'b1; w_rd_size = c_SZ_B; end
      3'b101: begin w_rd_part = c_RP_HU; w_rd_legal = 1'b1; w_rd_size = c_SZ_H; end
      default: begin w_rd_part = c_RP_W; w_rd_legal = 1'b0; w_rd_size = c_SZ_W; end
    endcase
  end

  always_comb begin
    w_wr_part  = c_WP_W;
    w_wr_legal = 1'b0;
    w_wr_size  = c_SZ_W;
    case (ls_funct3)
      3'b000: begin w_wr_part = c_WP_B; w_wr_legal = 1'b1; w_wr_size = c_SZ_B; end
      3'b001: begin w_wr_part = c_WP_H; w_wr_legal = 1'b1; w_wr_size = c_SZ_H; end
      3'b010: begin w_wr_part = c_WP_W; w_wr_legal = 1'b1; w_wr_size = c_SZ_W; end
      default: begin w_wr_part = c_WP_W; w_wr_legal = 1'b0; w_wr_size = c_SZ_W; end
    endcase
  end

  assign w_size  = ls_write ? w_wr_size  : w_rd_size;
  assign w_legal = ls_write ? w_wr_legal : w_rd_legal;

  always_comb begin
    w_aligned = 1'b1;
    case (w_size)
      c_SZ_W:  w_aligned = (ls_addr[1:0] == 2'b00);
      c_SZ_H:  w_aligned = (ls_addr[0] == 1'b0);
      default: w_aligned = 1'b1;
    endcase
  end

  // A simultaneous load+store is illegal; so is a cycle with no request at all.
  assign w_ok = w_ls_req & ~(ls_read & ls_write) & w_legal & w_aligned;

  assign mem_addr       = w_is_data ? ls_addr : if_addr;
  assign mem_read       = w_is_fetch ? if_req : (w_is_data & ls_read & w_ok);
  assign mem_write      = w_is_data & ls_write & w_ok;
  assign mem_read_part  = w_is_data ? w_rd_part : c_RP_W;
  assign mem_write_part = w_wr_part;
  assign mem_wdata      = ls_wdata;

  assign stall    = w_ls_req & ~r_ls_done;
  assign if_inst  = r_if_inst;
  assign if_valid = r_if_valid;
  assign ls_rdata = r_ls_rdata;
  assign ls_done  = r_ls_done;
  assign ls_fault = r_ls_fault;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_if_inst  <= 32'd0;
      r_if_valid <= 1'b0;
      r_ls_rdata <= 32'd0;
      r_ls_done  <= 1'b0;
      r_ls_fault <= 1'b0;
    end else begin
      r_ls_done  <= 1'b0;
      r_ls_fault <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_if_valid <= 1'b0;
          r_state    <= S_FETCH;
        end
        S_FETCH: begin
          r_if_inst  <= mem_rdata;
          r_if_valid <= if_req;
          // The ls_done cycle blocks a re-grant so a held request is served once.
          if (w_ls_req && !r_ls_done) begin
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          r_if_valid <= 1'b0;
          r_ls_done  <= 1'b1;
          r_ls_fault <= ~w_ok;
          r_ls_rdata <= (ls_read & w_ok) ? mem_rdata : 32'd0;
          r_state    <= S_FETCH;
        end
        default: begin
          r_if_valid <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

`ifdef ARB_STATS_EN
  localparam logic [STAT_W-1:0] c_STAT_ONE = {{(STAT_W-1){1'b0}}, 1'b1};

  logic [STAT_W-1:0] r_stat_fetch;
  logic [STAT_W-1:0] r_stat_stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stat_fetch <= '0;
      r_stat_stall <= '0;
    end else begin
      if (w_is_fetch && if_req && !(&r_stat_fetch)) begin
        r_stat_fetch <= r_stat_fetch + c_STAT_ONE;
      end
      if (stall && !(&r_stat_stall)) begin
        r_stat_stall <= r_stat_stall + c_STAT_ONE;
      end
    end
  end

  assign stat_fetch = r_stat_fetch;
  assign stat_stall = r_stat_stall;
`else
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// Module   : tb_mem_port_arbiter
// Purpose  : Scoreboard bench for mem_port_arbiter with a byte-array memory.
// Revision : 1.0 - initial release
// ------------------------------------------------------------------
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [7:0]  if_addr;
  logic [31:0] if_inst;
  logic        if_valid;
  logic        ls_read;
  logic        ls_write;
  logic [2:0]  ls_funct3;
  logic [7:0]  ls_addr;
  logic [31:0] ls_wdata;
  logic [31:0] ls_rdata;
  logic        ls_done;
  logic        ls_fault;
  logic        stall;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  mem_read_part;
  logic [1:0]  mem_write_part;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
`ifdef ARB_STATS_EN
  logic [15:0] stat_fetch;
  logic [15:0] stat_stall;
`endif

  mem_port_arbiter #(
    .ADDR_W(8)
`ifdef ARB_STATS_EN
    ,
    .STAT_W(16)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_inst(if_inst), .if_valid(if_valid),
    .ls_read(ls_read), .ls_write(ls_write), .ls_funct3(ls_funct3),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_rdata(ls_rdata),
    .ls_done(ls_done), .ls_fault(ls_fault), .stall(stall),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_read_part(mem_read_part), .mem_write_part(mem_write_part),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
`ifdef ARB_STATS_EN
    .stat_fetch(stat_fetch), .stat_stall(stat_stall),
`endif
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Little-endian byte memory: combinational read, store on the falling edge.
  logic [7:0] mem [0:255];

  always_comb begin
    mem_rdata = 32'd0;
    case (mem_read_part)
      3'd0: mem_rdata = {mem[mem_addr + 8'd3], mem[mem_addr + 8'd2],
                         mem[mem_addr + 8'd1], mem[mem_addr]};
      3'd1: mem_rdata = {{16{mem[mem_addr + 8'd1][7]}}, mem[mem_addr + 8'd1], mem[mem_addr]};
      3'd2: mem_rdata = {16'd0, mem[mem_addr + 8'd1], mem[mem_addr]};
      3'd3: mem_rdata = {{24{mem[mem_addr][7]}}, mem[mem_addr]};
      3'd4: mem_rdata = {24'd0, mem[mem_addr]};
      default: mem_rdata = 32'd0;
    endcase
  end

  always @(negedge clk) begin
    if (mem_write) begin
      case (mem_write_part)
        2'd0: begin
          mem[mem_addr]        <= mem_wdata[7:0];
          mem[mem_addr + 8'd1] <= mem_wdata[15:8];
          mem[mem_addr + 8'd2] <= mem_wdata[23:16];
          mem[mem_addr + 8'd3] <= mem_wdata[31:24];
        end
        2'd1: begin
          mem[mem_addr]        <= mem_wdata[7:0];
          mem[mem_addr + 8'd1] <= mem_wdata[15:8];
        end
        2'd2: mem[mem_addr] <= mem_wdata[7:0];
        default: ;
      endcase
    end
  end

  function automatic logic [31:0] word_at(input logic [7:0] a);
    return {mem[a + 8'd3], mem[a + 8'd2], mem[a + 8'd1], mem[a]};
  endfunction

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    string       nm;
  } ls_exp_t;

  logic [31:0] exp_if[$];
  ls_exp_t     exp_ls[$];
  int          total = 0;
  int          bad   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every presented response is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      if (if_valid) begin
        if (exp_if.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected if_valid: got if_inst=%h expected no fetch", if_inst);
        end else begin
          check("if_inst", if_inst, exp_if.pop_front());
        end
      end
      if (ls_done) begin
        if (exp_ls.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected ls_done: got rdata=%h fault=%b expected none", ls_rdata, ls_fault);
        end else begin
          ls_exp_t e;
          e = exp_ls.pop_front();
          check({e.nm, " ls_rdata"}, ls_rdata, e.rdata);
          check({e.nm, " ls_fault"}, {31'd0, ls_fault}, {31'd0, e.fault});
        end
      end
    end
  end

  // Called just after a posedge with the arbiter in FETCH; returns likewise.
  task automatic do_access(input string nm, input logic rd, input logic wr,
                           input logic [2:0] f3, input logic [7:0] a,
                           input logic [31:0] wd, input logic [31:0] exp_rd,
                           input logic exp_flt);
    int  stalls;
    int  acc;
    int  cyc;
    bit  done;
    exp_ls.push_back('{exp_rd, exp_flt, nm});
    ls_read = rd; ls_write = wr; ls_funct3 = f3; ls_addr = a; ls_wdata = wd;
    stalls = 0; acc = 0; cyc = 0; done = 0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (stall) stalls++;
      if (mem_read | mem_write) acc++;
      if (ls_done) done = 1;
    end
    @(posedge clk); #1;
    ls_read = 0; ls_write = 0;
    check({nm, " done seen"}, {31'd0, done}, 32'd1);
    check({nm, " stall cycles"}, stalls, 32'd2);
    check({nm, " mem accesses"}, acc, exp_flt ? 32'd0 : 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'h17; mem[1] = 8'h95;
    rst = 0; if_req = 0; if_addr = 8'h00;
    ls_read = 0; ls_write = 0; ls_funct3 = 3'd0; ls_addr = 8'h00; ls_wdata = 32'd0;

    repeat (3) @(negedge clk);
    check("rst if_valid", {31'd0, if_valid}, 32'd0);
    check("rst if_inst", if_inst, 32'd0);
    check("rst ls_done", {31'd0, ls_done}, 32'd0);
    check("rst mem_read", {31'd0, mem_read}, 32'd0);
`ifdef ARB_STATS_EN
    check("rst stat_fetch", {16'd0, stat_fetch}, 32'd0);
    check("rst stat_stall", {16'd0, stat_stall}, 32'd0);
`endif

    // Fetch word 0 right after reset release: IDLE, FETCH, then if_valid.
    rst = 1; if_req = 1; if_addr = 8'h00;
    exp_if.push_back(32'h00009517);
    #1 check("idle mem_read", {31'd0, mem_read}, 32'd0);
    @(posedge clk); #1;
    check("fetch mem_read", {31'd0, mem_read}, 32'd1);
    check("fetch if_valid early", {31'd0, if_valid}, 32'd0);
    @(posedge clk); #1;
    if_req = 0;
    @(posedge clk); #1;
    check("if_valid drop", {31'd0, if_valid}, 32'd0);

    do_access("SW 10",   1'b0, 1'b1, 3'b010, 8'h10, 32'hDEADBEEF, 32'h00000000, 1'b0);
    check("word4 after SW", word_at(8'h10), 32'hDEADBEEF);
    do_access("LB 13",   1'b1, 1'b0, 3'b000, 8'h13, 32'd0, 32'hFFFFFFDE, 1'b0);
    do_access("LHU 12",  1'b1, 1'b0, 3'b101, 8'h12, 32'd0, 32'h0000DEAD, 1'b0);
    do_access("LH 12",   1'b1, 1'b0, 3'b001, 8'h12, 32'd0, 32'hFFFFDEAD, 1'b0);
    do_access("LBU 11",  1'b1, 1'b0, 3'b100, 8'h11, 32'd0, 32'h000000BE, 1'b0);
    do_access("LW 11",   1'b1, 1'b0, 3'b010, 8'h11, 32'd0, 32'h00000000, 1'b1);
    do_access("SH 13",   1'b0, 1'b1, 3'b001, 8'h13, 32'h00001234, 32'h00000000, 1'b1);
    check("word4 after SH fault", word_at(8'h10), 32'hDEADBEEF);
    do_access("L f3=011", 1'b1, 1'b0, 3'b011, 8'h10, 32'd0, 32'h00000000, 1'b1);
    do_access("RD+WR",   1'b1, 1'b1, 3'b010, 8'h10, 32'h11111111, 32'h00000000, 1'b1);
    check("word4 after RD+WR", word_at(8'h10), 32'hDEADBEEF);
    do_access("SB 11",   1'b0, 1'b1, 3'b000, 8'h11, 32'h000000AA, 32'h00000000, 1'b0);
    do_access("LW 10",   1'b1, 1'b0, 3'b010, 8'h10, 32'd0, 32'hDEADAAEF, 1'b0);

    // A load held continuously for two grants: DATA cycles three apart.
    begin
      int acc;
      int dones;
      int first_acc;
      int gap;
      acc = 0; dones = 0; first_acc = -1; gap = 0;
      exp_ls.push_back('{32'h00009517, 1'b0, "held LW#1"});
      exp_ls.push_back('{32'h00009517, 1'b0, "held LW#2"});
      ls_read = 1; ls_funct3 = 3'b010; ls_addr = 8'h00;
      for (int c = 1; c <= 20 && dones < 2; c++) begin
        @(negedge clk);
        if (mem_read) begin
          acc++;
          if (first_acc < 0) first_acc = c;
          else gap = c - first_acc;
        end
        if (ls_done) dones++;
      end
      @(posedge clk); #1;
      ls_read = 0;
      check("held accesses", acc, 32'd2);
      check("held DATA spacing", gap, 32'd3);
    end
    repeat (2) @(posedge clk);
    #1;

    // Reset inside a store's DATA cycle, before the falling edge.
    ls_write = 1; ls_funct3 = 3'b010; ls_addr = 8'h20; ls_wdata = 32'h12345678;
    @(posedge clk); #2;
    check("mid-store mem_write", {31'd0, mem_write}, 32'd1);
    rst = 0; ls_write = 0;
    #1;
    check("async if_inst", if_inst, 32'd0);
    check("async ls_rdata", ls_rdata, 32'd0);
    check("async outs", {26'd0, if_valid, ls_done, ls_fault, mem_read, mem_write, stall}, 32'd0);
    @(negedge clk); #1;
    check("word8 untouched", word_at(8'h20), 32'h00000000);
`ifdef ARB_STATS_EN
    check("clr stat_fetch", {16'd0, stat_fetch}, 32'd0);
    check("clr stat_stall", {16'd0, stat_stall}, 32'd0);
`endif
    repeat (2) @(negedge clk);
    rst = 1;
    repeat (4) @(negedge clk);
    #1;
    check("exp_ls drained", exp_ls.size(), 32'd0);
    check("exp_if drained", exp_if.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
